parity_frame_tx: RTL and testbench

Serial frame transmitter that sits directly downstream of the byte parity generator. It accepts one 8-bit data word per handshake and computes the word's parity bit. It then shifts out a fixed 11-bit frame on a single line: start bit (0), 8 data bits LSB first, parity bit, stop bit (1). Each bit is held for a programmable number of clock cycles.

---
 rtl/parity_frame_pkg.sv | 26 ++
 rtl/parity_frame_tx_bit_timer.sv | 35 +++
 rtl/parity_frame_tx.sv | 140 ++++++++++++++
 tb/tb_parity_frame_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_frame_pkg.sv
// Shared definitions for the serial parity frame transmitter.
//   state_e      : frame FSM states
//   FRAME_BITS   : bits per frame (start + 8 data + parity + stop)
//   START_BIT    : line level of the start bit
//   STOP_BIT     : line level of the stop bit and of the idle line
//   calc_parity  : parity of a byte; the parity generator and checker use it too
package parity_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int   FRAME_BITS = 11;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  // odd = 0 gives even parity (^data), odd = 1 gives odd parity (~^data)
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_frame_tx_bit_timer.sv
// Bit-period timer for parity_frame_tx.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   clear  : hold the count at zero
//   tick   : high on the last cycle of a bit period (count == CLKS_PER_BIT-1)
// The count runs 0..CLKS_PER_BIT-1 and wraps on tick; with CLKS_PER_BIT = 1
// it stays at zero and tick is high every cycle.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_r;

  // Bit-period counter: cleared while idle, wraps at the terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else if (clear || tick) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= count_r + CW'(1);
    end
  end

  assign tick = (count_r == LAST);

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter with parity.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   data_in    : byte to send, sampled only when accepted (valid && ready)
//   valid      : upstream has a byte on data_in
//   ready      : high exactly while idle
//   tx         : serial line, idles high; frame = start, 8 data LSB first,
//                parity, stop, each bit held CLKS_PER_BIT cycles
//   busy       : a frame is in progress
//   frame_done : one-cycle pulse on the last cycle of the stop bit
// All outputs decode only registered state, so tx has no path from the inputs.
module parity_frame_tx
  import parity_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD_PARITY   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam logic ODD_SEL = (ODD_PARITY != 0);

  state_e     state_r;
  state_e     state_next_s;
  logic [7:0] shift_r;
  logic       parity_r;
  logic [2:0] bit_idx_r;
  logic       tick_s;
  logic       accept_s;
  logic       timer_clear_s;
  logic       tx_s;

  assign accept_s      = valid && (state_r == IDLE);
  // Timer sits at zero while idle so the start bit gets a full period
  assign timer_clear_s = (state_r == IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(timer_clear_s),
    .tick (tick_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Shift register, latched parity and data bit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r   <= 8'h00;
      parity_r  <= 1'b0;
      bit_idx_r <= 3'd0;
    end else if (accept_s) begin
      shift_r   <= data_in;
      parity_r  <= calc_parity(data_in, ODD_SEL);
      bit_idx_r <= 3'd0;
    end else if ((state_r == DATA) && tick_s) begin
      // index wraps 7 -> 0 naturally as the FSM leaves DATA
      shift_r   <= {1'b0, shift_r[7:1]};
      bit_idx_r <= bit_idx_r + 3'd1;
    end else begin
      shift_r   <= shift_r;
      parity_r  <= parity_r;
      bit_idx_r <= bit_idx_r;
    end
  end

  // Next-state and line-level decode
  always_comb begin
    state_next_s = state_r;
    tx_s         = STOP_BIT;
    case (state_r)
      IDLE: begin
        tx_s = STOP_BIT;
        if (valid) begin
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        tx_s = START_BIT;
        if (tick_s) begin
          state_next_s = DATA;
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        tx_s = shift_r[0];
        if (tick_s && (bit_idx_r == 3'd7)) begin
          state_next_s = PARITY;
        end else begin
          state_next_s = DATA;
        end
      end
      PARITY: begin
        tx_s = parity_r;
        if (tick_s) begin
          state_next_s = STOP;
        end else begin
          state_next_s = PARITY;
        end
      end
      STOP: begin
        tx_s = STOP_BIT;
        if (tick_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = STOP;
        end
      end
      default: begin
        tx_s         = STOP_BIT;
        state_next_s = IDLE;
      end
    endcase
  end

  assign tx         = tx_s;
  assign ready      = (state_r == IDLE);
  assign busy       = (state_r != IDLE);
  assign frame_done = (state_r == STOP) && tick_s;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx.
// u_dut  : CLKS_PER_BIT=4, even parity, checked by a scoreboard monitor
// u_odd  : CLKS_PER_BIT=4, odd parity
// u_fast : CLKS_PER_BIT=1, even parity
module tb_parity_frame_tx;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  logic [7:0] data_in;
  logic       valid;
  logic       ready, tx, busy, frame_done;

  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_o, tx_o, busy_o, frame_done_o;

  logic [7:0] data_f;
  logic       valid_f;
  logic       ready_f, tx_f, busy_f, frame_done_f;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [10:0] frame;   // bit i is the i-th bit on the line
    int          acc;     // edge index of the accept
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t vecs[5];

  int          last_acc;
  int          mon_cnt = 0;
  logic [10:0] mon_bits;
  bit          pend_ready = 1'b0;

  parity_frame_tx #(.CLKS_PER_BIT(4), .ODD_PARITY(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid(valid),
    .ready(ready), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  parity_frame_tx #(.CLKS_PER_BIT(4), .ODD_PARITY(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .data_in(data_o), .valid(valid_o),
    .ready(ready_o), .tx(tx_o), .busy(busy_o), .frame_done(frame_done_o)
  );

  parity_frame_tx #(.CLKS_PER_BIT(1), .ODD_PARITY(0)) u_fast (
    .clk(clk), .rst_n(rst_n), .data_in(data_f), .valid(valid_f),
    .ready(ready_f), .tx(tx_f), .busy(busy_f), .frame_done(frame_done_f)
  );

  always #5 clk = ~clk;

  // Edge counter used for latency checks
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor for u_dut: samples each bit mid-period, compares on frame_done
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      mon_cnt    = 0;
      pend_ready = 1'b0;
    end else begin
      if (pend_ready) begin
        check("ready_after_done", {30'd0, ready, busy}, 32'h2);
        pend_ready = 1'b0;
      end
      if (busy) begin
        if (mon_cnt < 44 && (mon_cnt % 4) == 2) mon_bits[mon_cnt / 4] = tx;
        mon_cnt++;
      end
      if (frame_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_frame_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("frame_bits", {21'd0, mon_bits}, {21'd0, e.frame});
          check("done_latency", cyc - e.acc, 32'd43);
          check("frame_cycles", mon_cnt, 32'd44);
          pend_ready = 1'b1;
        end
        mon_cnt = 0;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic p, input bit hold);
    int   t = 0;
    exp_t e;
    @(negedge clk);
    while (!ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      data_in = d;
      valid   = 1'b1;
      @(posedge clk);
      #1;
      last_acc = cyc;
      e.frame  = {1'b1, p, d, 1'b0};
      e.acc    = cyc;
      sb_q.push_back(e);
      if (!hold) valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || busy || pend_ready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", {31'd0, (sb_q.size() == 0) && !busy}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first_acc;
    int          acc_l;
    int          pulses;
    logic [10:0] got;

    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b0};
    vecs[2] = '{8'h01, 1'b1};
    vecs[3] = '{8'h80, 1'b1};
    vecs[4] = '{8'h3C, 1'b0};

    rst_n   = 1'b0;
    valid   = 1'b0; data_in = 8'h00;
    valid_o = 1'b0; data_o  = 8'h00;
    valid_f = 1'b0; data_f  = 8'h00;
    #1;
    check("reset_state", {28'd0, tx, ready, busy, frame_done}, 32'hC);
    check("reset_state_fast", {28'd0, tx_f, ready_f, busy_f, frame_done_f}, 32'hC);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle line holds with valid low
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_hold", {28'd0, tx, ready, busy, frame_done}, 32'hC);
    end

    // Table-driven frames; the first also checks tx falls right after accept
    foreach (vecs[i]) begin
      send(vecs[i].data, vecs[i].par, 1'b0);
      if (i == 0) check("start_bit_first_cycle", {31'd0, tx}, 32'd0);
      wait_idle();
    end

    // Back-to-back with valid held: 07 then FF, one idle cycle between
    send(8'h07, 1'b1, 1'b1);
    first_acc = last_acc;
    send(8'hFF, 1'b0, 1'b0);
    check("b2b_spacing", last_acc - first_acc, 32'd45);
    wait_idle();

    // Asynchronous reset during DATA bit 3 of 3C
    send(8'h3C, 1'b0, 1'b0);
    repeat (17) @(posedge clk);
    #2;
    check("busy_before_abort", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_async", {28'd0, tx, ready, busy, frame_done}, 32'hC);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h3C, 1'b0, 1'b0);
    wait_idle();

    // valid pulse with new data mid-frame must not disturb the frame in flight
    send(8'h5A, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("ready_low_mid_frame", {31'd0, ready}, 32'd0);
    data_in = 8'hFF;
    valid   = 1'b1;
    @(negedge clk);
    valid   = 1'b0;
    data_in = 8'h00;
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_second_accept", {31'd0, busy}, 32'd0);
    end

    // Odd parity, A5 -> parity bit 1
    @(negedge clk);
    data_o  = 8'hA5;
    valid_o = 1'b1;
    @(posedge clk);
    #1;
    valid_o = 1'b0;
    got     = 11'd0;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      if ((k % 4) == 2) got[k / 4] = tx_o;
      if (k == 43) check("odd_frame_done", {31'd0, frame_done_o}, 32'd1);
    end
    check("odd_frame_bits", {21'd0, got}, {21'd0, 11'b1_1_10100101_0});

    // CLKS_PER_BIT=1: 11-cycle frame, frame_done on the 11th cycle only
    @(negedge clk);
    data_f  = 8'h07;
    valid_f = 1'b1;
    @(posedge clk);
    #1;
    acc_l   = cyc;
    valid_f = 1'b0;
    got     = 11'd0;
    pulses  = 0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      got[k] = tx_f;
      if (frame_done_f) begin
        pulses++;
        check("fast_done_cycle", cyc - acc_l, 32'd10);
      end
    end
    check("fast_frame_bits", {21'd0, got}, {21'd0, 11'b1_1_00000111_0});
    check("fast_done_pulses", pulses, 32'd1);
    @(negedge clk);
    check("fast_ready_after", {30'd0, ready_f, busy_f}, 32'h2);

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
